// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: data width, alu
// operation codes, funct3 codes, state encoding and small op decode helpers.
package muldiv_seq_pkg;

  localparam int XLEN = 32;
  localparam int CW   = $clog2(XLEN);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_LTU = 4'b0011;

  localparam logic [2:0] MD_MUL  = 3'b000;
  localparam logic [2:0] MD_DIV  = 3'b100;
  localparam logic [2:0] MD_DIVU = 3'b101;
  localparam logic [2:0] MD_REM  = 3'b110;
  localparam logic [2:0] MD_REMU = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_MUL_STEP = 4'd1,
    ST_NEG_A    = 4'd2,
    ST_NEG_B    = 4'd3,
    ST_DIV_CMP  = 4'd4,
    ST_DIV_SUB  = 4'd5,
    ST_FIX_Q    = 4'd6,
    ST_FIX_R    = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

  // funct3 001..011 are not part of the supported subset
  function automatic logic md_illegal(input logic [2:0] op);
    return !op[2] && (op != MD_MUL);
  endfunction

  function automatic logic md_signed(input logic [2:0] op);
    return op[2] && !op[0];
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV/DIVU/REM/REMU sequencer. All arithmetic goes through an
// external combinational alu; this block only sequences operands and latches results.
//
// state       | meaning
// ST_IDLE     | ready for a request, alu parked at ADD(0,0)
// ST_MUL_STEP | one shift-add step per cycle, 32 steps
// ST_NEG_A    | take magnitude of a signed negative dividend
// ST_NEG_B    | take magnitude of a signed negative divisor
// ST_DIV_CMP  | shift next dividend bit into rem, compare against divisor
// ST_DIV_SUB  | conditional subtract, set quotient bit
// ST_FIX_Q    | negate quotient when operand signs differ
// ST_FIX_R    | negate remainder when dividend was negative
// ST_DONE     | result held until the consumer takes it
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy,
  output logic [XLEN-1:0] alu_in_0,
  output logic [XLEN-1:0] alu_in_1,
  output logic [3:0]      alu_operation,
  input  logic [XLEN-1:0] alu_out
);

  state_t state, state_nxt;

  logic [2:0]      op;
  logic [XLEN-1:0] a, b, acc, mcand, mplier, rem, q, result;
  logic            sa, sb, lt;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0] rem_next, rem_upd, q_upd;
  logic            fix_q, fix_r;

  assign fix_q = (op == MD_DIV) && (sa ^ sb);
  assign fix_r = (op == MD_REM) && sa;

  assign req_ready   = (state == ST_IDLE);
  assign resp_valid  = (state == ST_DONE);
  assign busy        = (state != ST_IDLE);
  assign resp_result = result;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    alu_operation = ALU_ADD;
    alu_in_0      = '0;
    alu_in_1      = '0;
    rem_next      = {rem[XLEN-2:0], a[cnt]};
    rem_upd       = lt ? rem : alu_out;
    q_upd         = q;
    if (!lt) q_upd[cnt] = 1'b1;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (md_illegal(req_op))                     state_nxt = ST_DONE;
          else if (req_op == MD_MUL)                  state_nxt = ST_MUL_STEP;
          else if (req_b == '0)                       state_nxt = ST_DONE;
          else if (md_signed(req_op) && req_a[XLEN-1]) state_nxt = ST_NEG_A;
          else if (md_signed(req_op) && req_b[XLEN-1]) state_nxt = ST_NEG_B;
          else                                        state_nxt = ST_DIV_CMP;
        end
      end
      ST_MUL_STEP: begin
        alu_in_0 = acc;
        alu_in_1 = mplier[0] ? mcand : '0;
        if (cnt == CW'(XLEN-1)) state_nxt = ST_DONE;
      end
      ST_NEG_A: begin
        alu_operation = ALU_SUB;
        alu_in_1      = a;
        state_nxt     = sb ? ST_NEG_B : ST_DIV_CMP;
      end
      ST_NEG_B: begin
        alu_operation = ALU_SUB;
        alu_in_1      = b;
        state_nxt     = ST_DIV_CMP;
      end
      ST_DIV_CMP: begin
        alu_operation = ALU_LTU;
        alu_in_0      = rem_next;
        alu_in_1      = b;
        state_nxt     = ST_DIV_SUB;
      end
      ST_DIV_SUB: begin
        alu_operation = ALU_SUB;
        alu_in_0      = rem;
        alu_in_1      = b;
        if (cnt != '0)  state_nxt = ST_DIV_CMP;
        else if (fix_q) state_nxt = ST_FIX_Q;
        else if (fix_r) state_nxt = ST_FIX_R;
        else            state_nxt = ST_DONE;
      end
      ST_FIX_Q: begin
        alu_operation = ALU_SUB;
        alu_in_1      = q;
        state_nxt     = ST_DONE;
      end
      ST_FIX_R: begin
        alu_operation = ALU_SUB;
        alu_in_1      = rem;
        state_nxt     = ST_DONE;
      end
      ST_DONE: begin
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= '0;
      a      <= '0;
      b      <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      q      <= '0;
      lt     <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op     <= req_op;
            a      <= req_a;
            b      <= req_b;
            sa     <= md_signed(req_op) & req_a[XLEN-1];
            sb     <= md_signed(req_op) & req_b[XLEN-1];
            acc    <= '0;
            mcand  <= req_a;
            mplier <= req_b;
            rem    <= '0;
            q      <= '0;
            lt     <= 1'b0;
            // multiply counts up, division walks bit index down
            cnt    <= (req_op == MD_MUL) ? '0 : CW'(XLEN-1);
            if (md_illegal(req_op))                   result <= '0;
            else if (req_op != MD_MUL && req_b == '0) result <= req_op[1] ? req_a : '1;
          end
        end
        ST_MUL_STEP: begin
          acc    <= alu_out;
          mcand  <= {mcand[XLEN-2:0], 1'b0};
          mplier <= {1'b0, mplier[XLEN-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) result <= alu_out;
        end
        ST_NEG_A:   a <= alu_out;
        ST_NEG_B:   b <= alu_out;
        ST_DIV_CMP: begin
          rem <= rem_next;
          lt  <= alu_out[0];
        end
        ST_DIV_SUB: begin
          rem <= rem_upd;
          q   <= q_upd;
          cnt <= cnt - CW'(1);
          if (cnt == '0 && !fix_q && !fix_r) result <= op[1] ? rem_upd : q_upd;
        end
        ST_FIX_Q: begin
          q      <= alu_out;
          result <= alu_out;
        end
        ST_FIX_R: begin
          rem    <= alu_out;
          result <= alu_out;
        end
        default: ;
      endcase
    end
  end

endmodule
